// File: rtl/nco_sweep_ctrl_pkg.sv
// nco_sweep_ctrl_pkg: shared state encoding and sweep mode codes for the NCO sweep controller
package nco_sweep_ctrl_pkg;
    typedef enum logic [2:0] {S_IDLE, S_PRIME, S_DWELL, S_STEP, S_END, S_DONE} state_t;
    localparam logic [1:0] MODE_SINGLE = 2'd0;
    localparam logic [1:0] MODE_REPEAT = 2'd1;
    localparam logic [1:0] MODE_TRI    = 2'd2;
endpackage

// File: rtl/nco_sweep_ctrl_next.sv
// nco_sweep_ctrl_next: next tuning word clamped to the endpoint, plus endpoint-reached flag
module nco_sweep_ctrl_next #(
    parameter int apr = 32
) (
    input  logic [apr-1:0] cur,
    input  logic [apr-1:0] step,
    input  logic [apr-1:0] endpoint,
    input  logic           dir_down,
    output logic [apr-1:0] next,
    output logic           at_end
);
    logic [apr:0] sum;
    logic [apr:0] diff;
    always_comb begin
        sum    = {1'b0, cur} + {1'b0, step};
        diff   = {1'b0, cur} - {1'b0, step};
        // carry/borrow out of apr bits or overshoot both land exactly on the endpoint
        next   = dir_down ? ((diff[apr] || diff[apr-1:0] < endpoint) ? endpoint : diff[apr-1:0])
                          : ((sum[apr]  || sum[apr-1:0]  > endpoint) ? endpoint : sum[apr-1:0]);
        at_end = cur == endpoint;
    end
endmodule

// File: rtl/nco_sweep_ctrl.sv
// nco_sweep_ctrl: sweeps the NCO tuning word from f_start to f_stop with programmable step/dwell
module nco_sweep_ctrl
    import nco_sweep_ctrl_pkg::*;
#(
    parameter int apr = 32,
    parameter int dw  = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic           abort,
    input  logic [apr-1:0] f_start,
    input  logic [apr-1:0] f_stop,
    input  logic [apr-1:0] f_step,
    input  logic [dw-1:0]  dwell,
    input  logic [1:0]     mode,
    input  logic           nco_valid,
    output logic [apr-1:0] phi_inc_o,
    output logic           nco_clken,
    output logic           busy,
    output logic           done,
    output logic           dir_down
);
    state_t         state, state_nx;
    logic [apr-1:0] start_r, step_r, lo, hi, ep, nxt;
    logic [dw-1:0]  dwell_r, cnt;
    logic [1:0]     mode_r;
    logic           dir0, at_end, done_r;

    // the endpoint follows the travel direction, so triangle mode swaps it just by toggling dir_down
    assign ep = dir_down ? lo : hi;

    nco_sweep_ctrl_next #(.apr(apr)) u_next (
        .cur(phi_inc_o),
        .step(step_r),
        .endpoint(ep),
        .dir_down(dir_down),
        .next(nxt),
        .at_end(at_end)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        if (abort) state_nx = S_IDLE;
        else
            case (state)
                S_IDLE, S_DONE: state_nx = start ? S_PRIME : state;
                S_PRIME:        state_nx = nco_valid ? S_DWELL : S_PRIME;
                S_DWELL:        state_nx = (cnt == '0) ? (at_end ? S_END : S_STEP) : S_DWELL;
                S_STEP:         state_nx = S_DWELL;
                S_END:          state_nx = (mode_r == MODE_REPEAT) ? S_DWELL :
                                           (mode_r == MODE_TRI) ? S_STEP : S_DONE;
                default:        state_nx = S_IDLE;
            endcase
    end

    always_comb begin
        nco_clken = state != S_IDLE;
        busy      = state != S_IDLE && state != S_DONE;
        done      = done_r;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phi_inc_o <= '0;
            dir_down  <= 1'b0;
            dir0      <= 1'b0;
            start_r   <= '0;
            step_r    <= '0;
            lo        <= '0;
            hi        <= '0;
            dwell_r   <= '0;
            cnt       <= '0;
            mode_r    <= MODE_SINGLE;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (!abort)
                case (state)
                    S_IDLE, S_DONE:
                        if (start) begin
                            phi_inc_o <= f_start;
                            start_r   <= f_start;
                            step_r    <= f_step;
                            lo        <= (f_stop < f_start) ? f_stop : f_start;
                            hi        <= (f_stop < f_start) ? f_start : f_stop;
                            dir_down  <= f_stop < f_start;
                            dir0      <= f_stop < f_start;
                            dwell_r   <= (dwell == '0) ? '0 : dwell - dw'(1);
                            mode_r    <= mode;
                        end
                    S_PRIME: cnt <= dwell_r;
                    S_DWELL: cnt <= cnt - dw'(1);
                    S_STEP: begin
                        phi_inc_o <= nxt;
                        cnt       <= dwell_r;
                    end
                    S_END:
                        if (mode_r == MODE_REPEAT) begin
                            phi_inc_o <= start_r;
                            dir_down  <= dir0;
                            cnt       <= dwell_r;
                        end else if (mode_r == MODE_TRI) dir_down <= ~dir_down;
                        else done_r <= 1'b1;
                    default: ;
                endcase
        end
    end
endmodule

// File: tb/tb_nco_sweep_ctrl.sv
// tb_nco_sweep_ctrl: directed table of sweep configurations plus abort and async-reset sequences
module tb_nco_sweep_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [31:0] f_start = '0;
    logic [31:0] f_stop = '0;
    logic [31:0] f_step = '0;
    logic [15:0] dwell = '0;
    logic [1:0]  mode = '0;
    logic        nco_valid = 1'b0;
    logic [31:0] phi_inc_o;
    logic        nco_clken, busy, done, dir_down;
    int          n_tests = 0;
    int          n_fail = 0;

    typedef struct {
        logic [31:0]        fs, fe, st;
        logic [15:0]        dw;
        logic [1:0]         md;
        int                 vd, cyc, n;
        logic [0:5][31:0]   seq;
        int                 hold, dones;
        logic               busy_end, dir0;
    } vec_t;

    vec_t tv[8];

    nco_sweep_ctrl dut (
        .clk(clk), .reset(reset), .start(start), .abort(abort),
        .f_start(f_start), .f_stop(f_stop), .f_step(f_step), .dwell(dwell), .mode(mode),
        .nco_valid(nco_valid), .phi_inc_o(phi_inc_o), .nco_clken(nco_clken),
        .busy(busy), .done(done), .dir_down(dir_down)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        start = 1'b0;
        abort = 1'b0;
        nco_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic [31:0] fs, fe, st, input logic [15:0] dw, input logic [1:0] md,
                                input int vd, cyc, n, input logic [0:5][31:0] seq,
                                input int hold, dones, input logic busy_end, dir0);
        vec_t v;
        v.fs = fs; v.fe = fe; v.st = st; v.dw = dw; v.md = md; v.vd = vd; v.cyc = cyc; v.n = n;
        v.seq = seq; v.hold = hold; v.dones = dones; v.busy_end = busy_end; v.dir0 = dir0;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int id);
        logic [31:0] last;
        logic [31:0] got[$];
        int          hold, dn, dv, nch;
        do_reset();
        f_start = v.fs; f_stop = v.fe; f_step = v.st; dwell = v.dw; mode = v.md;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        f_start = $urandom; f_stop = $urandom; f_step = $urandom; dwell = 16'(5); mode = 2'(~v.md);
        chk($sformatf("v%0d_lat_phi", id), phi_inc_o, v.fs);
        chk($sformatf("v%0d_lat_clken_busy", id), {30'd0, nco_clken, busy}, 32'd3);
        chk($sformatf("v%0d_dir0", id), {31'd0, dir_down}, {31'd0, v.dir0});
        last = '0; hold = 0; dn = 0; dv = 0;
        for (int i = 0; i < v.cyc; i++) begin
            if (phi_inc_o !== last) begin
                got.push_back(phi_inc_o);
                last = phi_inc_o;
            end
            if (got.size() == 2) hold++;
            if (done) begin
                dn++;
                if (busy) dv++;
            end
            nco_valid = (i + 1 >= v.vd);
            @(negedge clk);
        end
        nch = got.size();
        chk($sformatf("v%0d_nvals", id), 32'((v.dones == 1 || v.n == 1) ? nch : (nch > v.n ? v.n : nch)), 32'(v.n));
        for (int i = 0; i < v.n && i < nch; i++)
            chk($sformatf("v%0d_seq%0d", id, i), got[i], v.seq[i]);
        chk($sformatf("v%0d_hold", id), 32'(hold), 32'(v.hold));
        chk($sformatf("v%0d_dones", id), 32'(dn), 32'(v.dones));
        chk($sformatf("v%0d_done_busy", id), 32'(dv), 32'd0);
        chk($sformatf("v%0d_busy_end", id), {31'd0, busy}, {31'd0, v.busy_end});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic wait_phi(input logic [31:0] val, input string nm);
        int k = 0;
        while (phi_inc_o !== val && k < 60) begin
            @(negedge clk);
            k++;
        end
        if (phi_inc_o !== val) chk({nm, "_timeout"}, phi_inc_o, val);
    endtask

    initial begin
        int dn, bz;
        tv[0] = mk(32'h100, 32'h400, 32'h100, 16'd3, 2'd0, 9, 60, 4,
                   {32'h100, 32'h200, 32'h300, 32'h400, 32'h0, 32'h0}, 4, 1, 1'b0, 1'b0);
        tv[1] = mk(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 16'd2, 2'd0, 1, 40, 3,
                   {32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0}, 3, 1, 1'b0, 1'b0);
        tv[2] = mk(32'h500, 32'h200, 32'h180, 16'd2, 2'd2, 1, 60, 6,
                   {32'h500, 32'h380, 32'h200, 32'h380, 32'h500, 32'h380}, 3, 0, 1'b1, 1'b1);
        tv[3] = mk(32'h10, 32'h30, 32'h10, 16'd1, 2'd1, 1, 40, 6,
                   {32'h10, 32'h20, 32'h30, 32'h10, 32'h20, 32'h30}, 2, 0, 1'b1, 1'b0);
        tv[4] = mk(32'h100, 32'h400, 32'h100, 16'd0, 2'd3, 1, 40, 4,
                   {32'h100, 32'h200, 32'h300, 32'h400, 32'h0, 32'h0}, 2, 1, 1'b0, 1'b0);
        tv[5] = mk(32'h1000, 32'h1000, 32'h40, 16'd2, 2'd0, 1, 30, 1,
                   {32'h1000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 0, 1, 1'b0, 1'b0);
        tv[6] = mk(32'h40, 32'h80, 32'h0, 16'd1, 2'd0, 1, 40, 1,
                   {32'h40, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 0, 0, 1'b1, 1'b0);
        tv[7] = mk(32'h70, 32'h70, 32'h10, 16'd1, 2'd2, 1, 40, 1,
                   {32'h70, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0}, 0, 0, 1'b1, 1'b0);

        do_reset();
        chk("rst_phi", phi_inc_o, 32'h0);
        chk("rst_flags", {28'd0, nco_clken, busy, done, dir_down}, 32'h0);

        for (int i = 0; i < 8; i++) run_vec(tv[i], i);

        // abort in DWELL at 0x300 with a simultaneous start; an earlier start while busy is ignored
        do_reset();
        f_start = 32'h100; f_stop = 32'h400; f_step = 32'h100; dwell = 16'd3; mode = 2'd0;
        nco_valid = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_phi(32'h200, "abort_wait200");
        f_start = 32'h900;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("busy_start_ignored", phi_inc_o, 32'h200);
        wait_phi(32'h300, "abort_wait300");
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        chk("abort_phi_hold", phi_inc_o, 32'h300);
        chk("abort_flags", {29'd0, nco_clken, busy, done}, 32'h0);
        dn = 0; bz = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            dn += int'(done);
            bz += int'(busy) + int'(nco_clken);
        end
        chk("abort_no_done", 32'(dn), 32'd0);
        chk("abort_stays_idle", 32'(bz), 32'd0);

        // async reset asserted off-edge during a STEP cycle
        do_reset();
        f_start = 32'h100; f_stop = 32'h400; f_step = 32'h100; dwell = 16'd0; mode = 2'd0;
        nco_valid = 1'b1;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_phi(32'h200, "areset_wait");
        @(negedge clk);
        chk("pre_areset_busy", {31'd0, busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("areset_phi", phi_inc_o, 32'h0);
        chk("areset_flags", {28'd0, nco_clken, busy, done, dir_down}, 32'h0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_areset_idle", {30'd0, nco_clken, busy}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
